accel_mem_cmd_issuer: RTL

- Upstream neighbour of the accelerator-to-memory bridge.
- Accepts accelerator load/store requests on a valid/ready port and buffers them in a small in-order FIFO.
- Packs each request into the bridge's 128-bit command word and drives it as an Avalon-MM master, honouring waitrequest.
- Returns sign- or zero-extended load data with a one-cycle valid pulse; flags and drops misaligned requests.

---
 rtl/accel_mem_cmd_issuer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/accel_mem_cmd_issuer.sv
// Accelerator request front-end: queues load/store requests in an in-order FIFO and
// issues them one at a time as packed 128-bit Avalon-MM commands to the memory bridge.
module accel_mem_cmd_issuer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [30:0]  req_addr,
    input  logic [1:0]   req_size,
    input  logic         req_signed,
    input  logic [63:0]  req_wdata,
    output logic         rsp_valid,
    output logic [63:0]  rsp_rdata,
    output logic         err_misaligned,
    output logic         avm_accel_address,
    output logic         avm_accel_write,
    output logic         avm_accel_read,
    output logic [127:0] avm_accel_writedata,
    input  logic [127:0] avm_accel_readdata,
    input  logic         avm_accel_waitrequest
);

    localparam int PTR_W = CNT_W - 1;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Request storage, one array per field
    logic        fifo_write_q  [DEPTH];
    logic [30:0] fifo_addr_q   [DEPTH];
    logic [1:0]  fifo_size_q   [DEPTH];
    logic        fifo_signed_q [DEPTH];
    logic [63:0] fifo_wdata_q  [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [0:0]   state_q, state_d;
    logic         read_q, read_d;
    logic         write_q, write_d;
    logic [127:0] cmd_q, cmd_d;
    logic [1:0]   size_q, size_d;
    logic         signed_q, signed_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic [63:0]  rsp_rdata_q, rsp_rdata_d;
    logic         err_q, err_d;

    logic        push, pop, load_cmd, mis_pop, complete, nonempty;
    logic        head_write, head_signed, head_mis;
    logic [30:0] head_addr;
    logic [1:0]  head_size;
    logic [63:0] head_wdata;
    logic [3:0]  head_bytes, head_off;
    logic        unused_readdata_hi;

    assign unused_readdata_hi = ^avm_accel_readdata[127:64];

    assign req_ready = (count_q != CNT_W'(DEPTH));
    assign nonempty  = (count_q != '0);
    assign push      = req_valid & req_ready;
    assign complete  = (state_q == BUSY) & ~avm_accel_waitrequest;
    assign pop       = ((state_q == IDLE) | complete) & nonempty;
    assign load_cmd  = pop & ~head_mis;
    assign mis_pop   = pop & head_mis;

    assign head_write  = fifo_write_q[rd_ptr_q];
    assign head_addr   = fifo_addr_q[rd_ptr_q];
    assign head_size   = fifo_size_q[rd_ptr_q];
    assign head_signed = fifo_signed_q[rd_ptr_q];
    assign head_wdata  = fifo_wdata_q[rd_ptr_q];

    // Misaligned when the access crosses an 8-byte word or is not naturally aligned
    assign head_bytes = 4'd1 << head_size;
    assign head_off   = {1'b0, head_addr[2:0]};
    assign head_mis   = ((head_off + head_bytes) > 4'd8) ||
                        ((head_off & (head_bytes - 4'd1)) != 4'd0);

    function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] sz,
                                           input logic sgn);
        logic [63:0] r;
        case (sz)
            2'd0:    r = {{56{sgn & d[7]}},  d[7:0]};
            2'd1:    r = {{48{sgn & d[15]}}, d[15:0]};
            2'd2:    r = {{32{sgn & d[31]}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        state_d     = state_q;
        read_d      = read_q;
        write_d     = write_q;
        cmd_d       = cmd_q;
        size_d      = size_q;
        signed_d    = signed_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        err_d       = err_q | mis_pop;

        if (complete) begin
            state_d = IDLE;
            read_d  = 1'b0;
            write_d = 1'b0;
            if (read_q) begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = extend(avm_accel_readdata[63:0], size_q, signed_q);
            end
        end

        // A new aligned head overrides the idle transition for back-to-back issue
        if (load_cmd) begin
            state_d  = BUSY;
            read_d   = ~head_write;
            write_d  = head_write;
            size_d   = head_size;
            signed_d = head_signed;
            cmd_d    = {29'd0, (head_size == 2'd3), (head_size == 2'd1), (head_size == 2'd0),
                        (head_write ? head_wdata : 64'd0), 1'b0, head_addr};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write_q[wr_ptr_q]  <= req_write;
            fifo_addr_q[wr_ptr_q]   <= req_addr;
            fifo_size_q[wr_ptr_q]   <= req_size;
            fifo_signed_q[wr_ptr_q] <= req_signed;
            fifo_wdata_q[wr_ptr_q]  <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            cmd_q       <= '0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            read_q      <= read_d;
            write_q     <= write_d;
            cmd_q       <= cmd_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
        end
    end

    assign avm_accel_address   = 1'b0;
    assign avm_accel_read      = read_q;
    assign avm_accel_write     = write_q;
    assign avm_accel_writedata = cmd_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_rdata           = rsp_rdata_q;
    assign err_misaligned      = err_q;

endmodule
